// File: rtl/npc_pkg.sv
// npc_pkg: shared widths, access-size encodings and LSU state type
package npc_pkg;
    localparam int XLEN = 64;
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;
    typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, RESP} lsu_state_t;
endpackage

// File: rtl/lsu_extend.sv
// lsu_extend: truncates right-aligned data to the access size and zero/sign-extends it
module lsu_extend
    import npc_pkg::*;
(
    input  logic [XLEN-1:0] raw,
    input  logic [1:0]      size,
    input  logic            uns,
    output logic [XLEN-1:0] ext
);
    // Fill the bits above the access width with zero or the access's top bit
    always_comb begin
        ext = raw;
        unique case (size)
            SZ_B: ext = {{(XLEN-8){~uns & raw[7]}}, raw[7:0]};
            SZ_H: ext = {{(XLEN-16){~uns & raw[15]}}, raw[15:0]};
            SZ_W: ext = {{(XLEN-32){~uns & raw[31]}}, raw[31:0]};
            SZ_D: ext = raw;
        endcase
    end
endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store back end that splits requests into aligned memory beats
module lsu_mem_master
    import npc_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1,
    parameter int XLEN = npc_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_wen,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic [XLEN-1:0] mem_raddr,
    output logic            mem_read,
    output logic [XLEN-1:0] mem_waddr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [7:0]      mem_wmask,
    output logic            mem_write,
    input  logic [XLEN-1:0] mem_rdata
);
    lsu_state_t state;
    logic wen_q, uns_q, cross_q, mem_read_q, mem_write_q;
    logic [1:0] size_q;
    logic [2:0] off_q, req_off;
    logic [3:0] req_n;
    logic req_cross;
    logic [15:0] m16_q, req_m16;
    logic [5:0] sh_lo;
    logic [6:0] sh_hi;
    logic [XLEN-1:0] wdata_q, lo, raw, ext;

    assign req_off = req_addr[2:0];
    assign req_n = 4'd1 << req_size;
    assign req_cross = {1'b0, req_off} + req_n > 4'd8;
    assign req_m16 = ((16'd1 << req_n) - 16'd1) << req_off;
    assign sh_lo = {off_q, 3'b000};
    assign sh_hi = 7'd64 - {1'b0, sh_lo};
    assign raw = state == BEAT2 ? lo | (mem_rdata << sh_hi) : mem_rdata >> sh_lo;
    assign mem_read = mem_read_q & ~rst;
    assign mem_write = mem_write_q & ~rst;

    lsu_extend u_extend (
        .raw  (raw),
        .size (size_q),
        .uns  (uns_q),
        .ext  (ext)
    );

    // Request sequencing: capture, one or two memory beats, then hold the response
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            resp_rdata  <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_wmask   <= 8'h00;
            mem_raddr   <= '0;
            mem_waddr   <= '0;
            mem_wdata   <= '0;
            wen_q       <= 1'b0;
            uns_q       <= 1'b0;
            cross_q     <= 1'b0;
            size_q      <= SZ_B;
            off_q       <= 3'd0;
            m16_q       <= 16'h0;
            wdata_q     <= '0;
            lo          <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid && req_ready) begin
                    wen_q     <= req_wen;
                    uns_q     <= req_unsigned;
                    cross_q   <= req_cross;
                    size_q    <= req_size;
                    off_q     <= req_off;
                    m16_q     <= req_m16;
                    wdata_q   <= req_wdata;
                    req_ready <= 1'b0;
                    if (req_cross && !ALLOW_MISALIGNED) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end else begin
                        state       <= BEAT1;
                        mem_read_q  <= ~req_wen;
                        mem_write_q <= req_wen;
                        mem_raddr   <= {req_addr[XLEN-1:3], 3'b000};
                        mem_waddr   <= {req_addr[XLEN-1:3], 3'b000};
                        mem_wmask   <= req_wen ? req_m16[7:0] : 8'h00;
                        mem_wdata   <= req_wdata << {req_off, 3'b000};
                    end
                end
                BEAT1: begin
                    lo <= raw;
                    if (cross_q) begin
                        state     <= BEAT2;
                        mem_raddr <= mem_raddr + XLEN'(8);
                        mem_waddr <= mem_waddr + XLEN'(8);
                        mem_wmask <= wen_q ? m16_q[15:8] : 8'h00;
                        mem_wdata <= wdata_q >> sh_hi;
                    end else begin
                        state       <= RESP;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        mem_wmask   <= 8'h00;
                        resp_valid  <= 1'b1;
                        resp_rdata  <= wen_q ? '0 : ext;
                    end
                end
                BEAT2: begin
                    state       <= RESP;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    mem_wmask   <= 8'h00;
                    resp_valid  <= 1'b1;
                    resp_rdata  <= wen_q ? '0 : ext;
                end
                RESP: if (resp_ready) begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: randomized and directed checks of lsu_mem_master against a byte-level memory model
module tb_lsu_mem_master;
    typedef struct {
        logic        wr;
        logic [63:0] a;
        logic [63:0] d;
        logic [7:0]  m;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, clr, req_valid, req_wen, req_unsigned, resp_ready;
    logic [63:0] req_addr, req_wdata;
    logic [1:0] req_size;
    logic req_ready, resp_valid, resp_err, mem_read, mem_write;
    logic [63:0] resp_rdata, mem_raddr, mem_waddr, mem_wdata, mem_rdata;
    logic [7:0] mem_wmask;

    logic r0_valid, r0_wen, r0_uns, p0_ready;
    logic [63:0] r0_addr, r0_wdata;
    logic [1:0] r0_size;
    logic q0_ready, p0_valid, p0_err, mem_read0, mem_write0;
    logic [63:0] p0_rdata, mem_raddr0, mem_waddr0, mem_wdata0, mem_rdata0;
    logic [7:0] mem_wmask0;
    assign mem_rdata0 = 64'h0123_4567_89ab_cdef;

    lsu_mem_master #(.ALLOW_MISALIGNED(1'b1)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_raddr(mem_raddr), .mem_read(mem_read), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    lsu_mem_master #(.ALLOW_MISALIGNED(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(r0_valid), .req_ready(q0_ready), .req_wen(r0_wen),
        .req_addr(r0_addr), .req_wdata(r0_wdata), .req_size(r0_size), .req_unsigned(r0_uns),
        .resp_valid(p0_valid), .resp_ready(p0_ready), .resp_rdata(p0_rdata), .resp_err(p0_err),
        .mem_raddr(mem_raddr0), .mem_read(mem_read0), .mem_waddr(mem_waddr0), .mem_wdata(mem_wdata0),
        .mem_wmask(mem_wmask0), .mem_write(mem_write0), .mem_rdata(mem_rdata0)
    );

    logic [7:0] dmem [0:255];
    logic [7:0] ref_mem [0:255];
    beat_t obs_q[$];
    int both_hi = 0, rd0_cnt = 0, wr0_cnt = 0;
    int total = 0, bad = 0;

    // Memory behind the DUT port: 256 bytes at 0x80000000, byte-masked writes
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) dmem[i] <= 8'h00;
        end else if (mem_write) begin
            for (int i = 0; i < 8; i++) if (mem_wmask[i]) dmem[{mem_waddr[7:3], 3'(i)}] <= mem_wdata[8*i +: 8];
        end
    end

    always_comb begin
        mem_rdata = '0;
        for (int i = 0; i < 8; i++) mem_rdata[8*i +: 8] = dmem[{mem_raddr[7:3], 3'(i)}];
    end

    // Log every memory strobe seen between clock edges
    always @(negedge clk) begin
        if (mem_read && mem_write) both_hi++;
        if (mem_read) obs_q.push_back('{1'b0, mem_raddr, 64'h0, mem_wmask});
        if (mem_write) obs_q.push_back('{1'b1, mem_waddr, mem_wdata, mem_wmask});
        if (mem_read0) rd0_cnt++;
        if (mem_write0) wr0_cnt++;
    end

    function automatic logic [63:0] ref_load(logic [63:0] a, logic [1:0] sz, bit un);
        int n;
        logic [63:0] v;
        n = 1 << sz;
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[8'(a[7:0] + 8'(i))];
        if (!un && v[8*n-1]) for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic ref_store(input logic [63:0] a, input logic [63:0] wd, input logic [1:0] sz);
        for (int i = 0; i < (1 << sz); i++) ref_mem[8'(a[7:0] + 8'(i))] = wd[8*i +: 8];
    endtask

    function automatic int exp_nb(logic [63:0] a, logic [1:0] sz);
        return ((a + 64'(1 << sz) - 64'd1) >> 3) == (a >> 3) ? 1 : 2;
    endfunction

    function automatic logic [7:0] exp_mask(logic [63:0] a, logic [1:0] sz, int k);
        logic [7:0] m;
        logic [63:0] b;
        m = '0;
        for (int i = 0; i < (1 << sz); i++) begin
            b = a + 64'(i);
            if ((b >> 3) == (a >> 3) + 64'(k)) m[b[2:0]] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [63:0] exp_data(logic [63:0] a, logic [1:0] sz, logic [63:0] wd, int k);
        logic [63:0] d, b;
        d = '0;
        for (int i = 0; i < (1 << sz); i++) begin
            b = a + 64'(i);
            if ((b >> 3) == (a >> 3) + 64'(k)) d[8*b[2:0] +: 8] = wd[8*i +: 8];
        end
        return d;
    endfunction

    function automatic logic [63:0] lanes(logic [7:0] m);
        logic [63:0] l;
        l = '0;
        for (int i = 0; i < 8; i++) l[8*i +: 8] = {8{m[i]}};
        return l;
    endfunction

    task automatic run(input bit w, input logic [63:0] a, input logic [63:0] wd, input logic [1:0] sz,
                       input bit un, output int lat, output int b0);
        @(negedge clk);
        b0 = obs_q.size();
        req_valid = 1'b1; req_wen = w; req_addr = a; req_wdata = wd; req_size = sz; req_unsigned = un;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic ack;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; clr = 1'b1;
        req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0; req_size = 0; req_unsigned = 0; resp_ready = 0;
        r0_valid = 0; r0_wen = 0; r0_addr = 0; r0_wdata = 0; r0_size = 0; r0_uns = 0; p0_ready = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({req_ready, resp_valid, resp_err, mem_read, mem_write, mem_wmask} !== {1'b1, 4'b0, 8'h00}) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=%b", {req_ready, resp_valid, resp_err, mem_read, mem_write, mem_wmask}, {1'b1, 12'b0});
        end
        total++;
        if ({mem_raddr, mem_waddr, mem_wdata, resp_rdata} !== 256'h0) begin
            bad++;
            $display("FAIL reset_data got=%h %h %h %h exp=0", mem_raddr, mem_waddr, mem_wdata, resp_rdata);
        end
        rst = 1'b0; clr = 1'b0;
    endtask

    task automatic test_aligned_d;
        int lat, b0;
        run(1, 64'h8000_0008, 64'h1122_3344_5566_7788, 2'd3, 0, lat, b0);
        ack();
        ref_store(64'h8000_0008, 64'h1122_3344_5566_7788, 2'd3);
        total++;
        if (obs_q.size() != b0 + 1 || obs_q[b0].a !== 64'h8000_0008 || obs_q[b0].m !== 8'hff || !obs_q[b0].wr) begin
            bad++;
            $display("FAIL st_d beat got=n%0d a=%h m=%h exp=n1 a=80000008 m=ff", obs_q.size() - b0, obs_q[b0].a, obs_q[b0].m);
        end
        run(0, 64'h8000_0008, 64'h0, 2'd3, 0, lat, b0);
        total++;
        if (resp_rdata !== 64'h1122_3344_5566_7788 || lat != 2) begin
            bad++;
            $display("FAIL ld_d got=%h lat=%0d exp=1122334455667788 lat=2", resp_rdata, lat);
        end
        total++;
        if (obs_q.size() != b0 + 1 || obs_q[b0].wr || obs_q[b0].a !== 64'h8000_0008 || obs_q[b0].m !== 8'h00) begin
            bad++;
            $display("FAIL ld_d beat got=n%0d a=%h m=%h exp=n1 a=80000008 m=00", obs_q.size() - b0, obs_q[b0].a, obs_q[b0].m);
        end
        ack();
    endtask

    task automatic test_signed_byte;
        int lat, b0;
        run(0, 64'h8000_000f, 64'h0, 2'd0, 0, lat, b0);
        total++;
        if (resp_rdata !== 64'h11) begin bad++; $display("FAIL ldb_11 got=%h exp=11", resp_rdata); end
        ack();
        run(1, 64'h8000_000f, 64'h80, 2'd0, 0, lat, b0);
        ack();
        ref_store(64'h8000_000f, 64'h80, 2'd0);
        run(0, 64'h8000_000f, 64'h0, 2'd0, 0, lat, b0);
        total++;
        if (resp_rdata !== 64'hffff_ffff_ffff_ff80) begin bad++; $display("FAIL ldb_sx got=%h exp=ffffffffffffff80", resp_rdata); end
        ack();
        run(0, 64'h8000_000f, 64'h0, 2'd0, 1, lat, b0);
        total++;
        if (resp_rdata !== 64'h80) begin bad++; $display("FAIL ldbu got=%h exp=80", resp_rdata); end
        ack();
    endtask

    task automatic test_store_half;
        int lat, b0;
        run(1, 64'h8000_0012, 64'habcd, 2'd1, 0, lat, b0);
        ref_store(64'h8000_0012, 64'habcd, 2'd1);
        total++;
        if (lat != 2 || obs_q.size() != b0 + 1 || obs_q[b0].a !== 64'h8000_0010 || obs_q[b0].m !== 8'h0c
            || obs_q[b0].d[31:16] !== 16'habcd || resp_rdata !== 64'h0) begin
            bad++;
            $display("FAIL st_h got=lat%0d n%0d a=%h m=%h d=%h r=%h exp=lat2 n1 a=80000010 m=0c d[31:16]=abcd r=0",
                     lat, obs_q.size() - b0, obs_q[b0].a, obs_q[b0].m, obs_q[b0].d, resp_rdata);
        end
        ack();
    endtask

    task automatic test_cross;
        int lat, b0;
        run(1, 64'h8000_001e, 64'hdead_beef, 2'd2, 0, lat, b0);
        ref_store(64'h8000_001e, 64'hdead_beef, 2'd2);
        total++;
        if (lat != 3 || obs_q.size() != b0 + 2) begin
            bad++;
            $display("FAIL st_x_shape got=lat%0d n%0d exp=lat3 n2", lat, obs_q.size() - b0);
        end
        total++;
        if (obs_q[b0].a !== 64'h8000_0018 || obs_q[b0].m !== 8'hc0 || obs_q[b0].d[63:48] !== 16'hbeef) begin
            bad++;
            $display("FAIL st_x_b1 got=a=%h m=%h d=%h exp=a=80000018 m=c0 d[63:48]=beef", obs_q[b0].a, obs_q[b0].m, obs_q[b0].d);
        end
        total++;
        if (obs_q[b0+1].a !== 64'h8000_0020 || obs_q[b0+1].m !== 8'h03 || obs_q[b0+1].d[15:0] !== 16'hdead) begin
            bad++;
            $display("FAIL st_x_b2 got=a=%h m=%h d=%h exp=a=80000020 m=03 d[15:0]=dead", obs_q[b0+1].a, obs_q[b0+1].m, obs_q[b0+1].d);
        end
        ack();
        run(0, 64'h8000_001e, 64'h0, 2'd2, 0, lat, b0);
        total++;
        if (resp_rdata !== 64'hffff_ffff_dead_beef || lat != 3) begin
            bad++;
            $display("FAIL ld_x got=%h lat=%0d exp=ffffffffdeadbeef lat=3", resp_rdata, lat);
        end
        ack();
    endtask

    task automatic test_backpressure;
        int lat, b0;
        logic [63:0] exp;
        exp = ref_load(64'h8000_0008, 2'd3, 0);
        run(0, 64'h8000_0008, 64'h0, 2'd3, 0, lat, b0);
        for (int c = 0; c < 5; c++) begin
            total++;
            if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_rdata !== exp) begin
                bad++;
                $display("FAIL bp_hold c%0d got=v%b rr%b %h exp=v1 rr0 %h", c, resp_valid, req_ready, resp_rdata, exp);
            end
            @(negedge clk);
        end
        ack();
    endtask

    task automatic test_reset_midflight;
        int lat, b0;
        logic [63:0] exp;
        exp = ref_load(64'h8000_0040, 2'd3, 1);
        @(negedge clk);
        b0 = obs_q.size();
        req_valid = 1; req_wen = 1; req_addr = 64'h8000_0040; req_wdata = 64'hcafe_f00d_1234_5678; req_size = 2'd3;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        rst = 1'b1;
        #1;
        total++;
        if (mem_write !== 1'b0 || mem_read !== 1'b0) begin bad++; $display("FAIL rst_gate got=w%b r%b exp=w0 r0", mem_write, mem_read); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({req_ready, resp_valid, mem_read, mem_write} !== 4'b1000) begin
            bad++;
            $display("FAIL rst_idle got=%b exp=1000", {req_ready, resp_valid, mem_read, mem_write});
        end
        repeat (4) @(negedge clk);
        total++;
        if (resp_valid !== 1'b0 || obs_q.size() != b0) begin
            bad++;
            $display("FAIL rst_drop got=v%b beats%0d exp=v0 beats0", resp_valid, obs_q.size() - b0);
        end
        run(0, 64'h8000_0040, 64'h0, 2'd3, 1, lat, b0);
        total++;
        if (resp_rdata !== exp) begin bad++; $display("FAIL rst_nowrite got=%h exp=%h", resp_rdata, exp); end
        ack();
    endtask

    task automatic test_random;
        int lat, b0, nb;
        bit w, un;
        logic [1:0] sz;
        logic [63:0] a, wd, exp;
        for (int t = 0; t < 60; t++) begin
            w = 1'($urandom_range(0, 1));
            un = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a = 64'h8000_0000 + 64'($urandom_range(0, 8'he7));
            wd = {$urandom, $urandom};
            nb = exp_nb(a, sz);
            exp = w ? 64'h0 : ref_load(a, sz, un);
            run(w, a, wd, sz, un, lat, b0);
            total++;
            if (lat != nb + 1 || obs_q.size() != b0 + nb || resp_rdata !== exp || resp_err !== 1'b0) begin
                bad++;
                $display("FAIL rnd%0d resp got=lat%0d n%0d %h e%b exp=lat%0d n%0d %h e0 (w%0d a=%h sz%0d)",
                         t, lat, obs_q.size() - b0, resp_rdata, resp_err, nb + 1, nb, exp, w, a, sz);
            end
            for (int k = 0; k < nb; k++) begin
                total++;
                if (obs_q[b0+k].wr !== w || obs_q[b0+k].a !== (((a >> 3) + 64'(k)) << 3)
                    || obs_q[b0+k].m !== (w ? exp_mask(a, sz, k) : 8'h00)
                    || (w && (obs_q[b0+k].d & lanes(obs_q[b0+k].m)) !== exp_data(a, sz, wd, k))) begin
                    bad++;
                    $display("FAIL rnd%0d beat%0d got=w%b a=%h m=%h d=%h exp=w%0d a=%h m=%h d=%h",
                             t, k, obs_q[b0+k].wr, obs_q[b0+k].a, obs_q[b0+k].m, obs_q[b0+k].d,
                             w, ((a >> 3) + 64'(k)) << 3, exp_mask(a, sz, k), exp_data(a, sz, wd, k));
                end
            end
            if (w) ref_store(a, wd, sz);
            ack();
        end
        total++;
        if (both_hi != 0) begin bad++; $display("FAIL both_strobes got=%0d exp=0", both_hi); end
    endtask

    task automatic test_no_misaligned;
        int r0, w0;
        @(negedge clk);
        r0 = rd0_cnt;
        r0_valid = 1; r0_wen = 0; r0_addr = 64'h8000_0004; r0_size = 2'd3; r0_uns = 0;
        @(posedge clk);
        @(negedge clk);
        r0_valid = 0;
        total++;
        if (p0_valid !== 1'b1 || p0_err !== 1'b1) begin bad++; $display("FAIL nomis_ld got=v%b e%b exp=v1 e1", p0_valid, p0_err); end
        p0_ready = 1; @(posedge clk); @(negedge clk); p0_ready = 0;
        w0 = wr0_cnt;
        r0_valid = 1; r0_wen = 1; r0_addr = 64'h8000_001e; r0_wdata = 64'hdead_beef; r0_size = 2'd2;
        @(posedge clk);
        @(negedge clk);
        r0_valid = 0;
        total++;
        if (p0_valid !== 1'b1 || p0_err !== 1'b1) begin bad++; $display("FAIL nomis_st got=v%b e%b exp=v1 e1", p0_valid, p0_err); end
        p0_ready = 1; @(posedge clk); @(negedge clk); p0_ready = 0;
        total++;
        if (rd0_cnt != r0 || wr0_cnt != w0) begin
            bad++;
            $display("FAIL nomis_nostrobe got=r%0d w%0d exp=r0 w0", rd0_cnt - r0, wr0_cnt - w0);
        end
        r0_valid = 1; r0_wen = 0; r0_addr = 64'h8000_0000; r0_size = 2'd3;
        @(posedge clk);
        @(negedge clk);
        r0_valid = 0;
        @(negedge clk);
        total++;
        if (p0_valid !== 1'b1 || p0_err !== 1'b0 || p0_rdata !== 64'h0123_4567_89ab_cdef || rd0_cnt != r0 + 1) begin
            bad++;
            $display("FAIL nomis_aligned got=v%b e%b %h r%0d exp=v1 e0 0123456789abcdef r1", p0_valid, p0_err, p0_rdata, rd0_cnt - r0);
        end
        p0_ready = 1; @(posedge clk); @(negedge clk); p0_ready = 0;
    endtask

    initial begin
        test_reset();
        test_aligned_d();
        test_signed_byte();
        test_store_half();
        test_cross();
        test_backpressure();
        test_reset_midflight();
        test_random();
        test_no_misaligned();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store unit back end. It is the initiator side of the core's data-memory port and drives the DPI-backed physical memory model.
- It accepts one load/store request at a time from the execute stage.
- It converts the request into 8-byte-aligned read/write beats with a byte mask. An access that crosses a dword boundary becomes two beats.
- It merges and sign/zero-extends load data, then returns one response per request with a valid/ready handshake.

Parameters:
- ALLOW_MISALIGNED, 1: when 1, a dword-crossing access is split into two beats; when 0, it completes as an error with no memory access.
- XLEN, 64: data and address width. Only 64 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_wen  in  1  1 = store, 0 = load
- req_addr  in  64  byte address
- req_wdata  in  64  store data, right-aligned
- req_size  in  2  access size: 0=B, 1=H, 2=W, 3=D
- req_unsigned  in  1  load zero-extend when 1, sign-extend when 0
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  64  extended load data; 0 for stores
- resp_err  out  1  misaligned-crossing access rejected (ALLOW_MISALIGNED=0 only)
- mem_raddr  out  64  read address, bits[2:0]=0
- mem_read  out  1  read strobe
- mem_waddr  out  64  write address, bits[2:0]=0
- mem_wdata  out  64  write data, lane-aligned
- mem_wmask  out  8  byte-lane write enables
- mem_write  out  1  write strobe
- mem_rdata  in  64  read data, valid combinationally in the same cycle as mem_read

Behaviour:
- States: IDLE, BEAT1, BEAT2, RESP.

Reset:
- Takes effect at the next clk edge and forces IDLE. It overrides a request or response in progress; that request is dropped with no response.
- Reset values: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_wmask=0, addresses/wdata=0.
- mem_read and mem_write are also gated low combinationally while rst=1.

Request capture:
- In IDLE, req_valid&&req_ready latches all req_* fields, then moves to BEAT1. If the access crosses a dword and ALLOW_MISALIGNED=0, it moves straight to RESP instead with resp_err=1.
- req_* fields are ignored outside IDLE.

Address and mask arithmetic:
- off = addr[2:0], n = 1<<size.
- cross = (off + n > 8).
- Full mask m16 = ((1<<n)-1) << off, 16 bits wide.
- Beat1: address = {addr[63:3],3'b0}, mask = m16[7:0], wdata = req_wdata << (8*off).
- Beat2: address = beat1 address + 8, mask = m16[15:8], wdata = req_wdata >> (8*(8-off)).

BEAT1:
- Drives mem_read (load) or mem_write (store) for exactly one cycle.
- mem_wmask is 0 for loads.
- Load: lo = mem_rdata >> (8*off) is captured.
- Next state is BEAT2 if cross, otherwise RESP.

BEAT2:
- Same as BEAT1 but for the upper dword, one cycle.
- Load: hi = mem_rdata << (8*(8-off)) is captured.
- raw = lo | hi. Next state is RESP.

RESP:
- resp_valid=1. resp_rdata is raw truncated to n bytes, then zero- or sign-extended to 64 bits.
- Outputs hold stable until resp_valid&&resp_ready, then the state returns to IDLE.
- No new request is accepted in the same cycle as the handshake (req_ready is low in RESP).

Latency:
- Accept at edge T.
- Single-beat access: resp_valid from T+2.
- Split access: resp_valid from T+3.
- Throughput is at most one request every 3 cycles (aligned).

Strobes:
- mem_read and mem_write are never both high.
- Both are low in IDLE and RESP.
- A store never drives mem_read.

Decomposition:
- Shared package (npc_pkg): XLEN constant, size encodings SZ_B/SZ_H/SZ_W/SZ_D, and the lsu_state_t enum.
- One natural sub-module, lsu_extend: combinational truncate plus sign/zero-extend from raw, size and unsigned. It is reusable by the CSR/atomic path.

Test Plan:
- Aligned load D: mem[0x80000008]=0x1122334455667788; load size=3 addr=0x80000008 -> one read at 0x80000008; resp_rdata=0x1122334455667788 at T+2.
- Signed byte load: same memory; load size=0 unsigned=0 addr=0x8000000F -> resp_rdata=0x0000000000000011. mem byte at 0x8000000F=0x80 -> 0xFFFFFFFFFFFFFF80. The same access with unsigned=1 -> 0x80.
- Store half mid-dword: store size=1 addr=0x80000012 wdata=0xABCD -> one write, waddr=0x80000010, wmask=0x0C, wdata[31:16]=0xABCD.
- Crossing word store: store size=2 addr=0x8000001E wdata=0xDEADBEEF ->
  - beat1: waddr 0x80000018, wmask 0xC0, wdata[63:48]=0xBEEF;
  - beat2: waddr 0x80000020, wmask 0x03, wdata[15:0]=0xDEAD;
  - resp at T+3.
  - A following word load from 0x8000001E returns 0xFFFFFFFFDEADBEEF (signed).
- Backpressure and reset: hold resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stable, req_ready=0. Then assert rst during BEAT1 of a new request -> next cycle IDLE, no mem strobe, no response.
- ALLOW_MISALIGNED=0: load size=3 addr=0x80000004 -> no mem_read, resp_valid with resp_err=1 at T+1.
